ps2_key_controller: RTL and testbench
=====================================

# ps2_key_controller

Synchronous PS/2 receive controller and scan-code sequencer between the keyboard pins and the character movement logic. It oversamples PS2_CLK/PS2_DAT in the Clock domain, frames and checks 11-bit packets, and recovers from stalled frames with a watchdog. It decodes E0/F0 prefix sequences into make/break events and keeps held-key state. It drives GoLeft/GoRight levels and a Jump pulse for the character logic.

## Interface
- TIMEOUT_CYCLES, 50000, Clock cycles without a PS2_CLK falling edge before an open frame is aborted (1 ms at 50 MHz)
- LEFT_CODE, 8'h6B, extended (E0-prefixed) code for left
- RIGHT_CODE, 8'h74, extended (E0-prefixed) code for right
- JUMP_CODE, 8'h29, non-extended code for jump (space)
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high
- PS2_CLK  input  1  raw keyboard clock, asynchronous
- PS2_DAT  input  1  raw keyboard data, asynchronous
- ScanCode  output  8  last good received byte
- ScanValid  output  1  one-cycle pulse, ScanCode updated
- FrameError  output  1  one-cycle pulse on a bad frame or a timeout
- GoLeft  output  1  level, left requested
- GoRight  output  1  level, right requested
- Jump  output  1  one-cycle pulse on the jump make event

## Operation
- Input stage: two-flop synchronizer on each pin, plus a registered previous PS2_CLK.
  - Falling edge = previous 1 and current 0. The synced data is sampled in that cycle ("edge cycle").
- Frame FSM (IDLE, DATA, PARITY, STOP), one transition per edge cycle:
  - IDLE: data 0 (start bit) -> DATA, bit count 0. Data 1 -> stay in IDLE (glitch ignored).
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop bit = 1 and the parity check passes, deliver the byte. Otherwise pulse FrameError. Always -> IDLE.
- Watchdog:
  - The counter clears on every edge cycle and in IDLE.
  - Outside IDLE it increments each cycle. At TIMEOUT_CYCLES-1 the FSM goes to IDLE and FrameError pulses.
  - The counter saturates and never wraps.
- Sequencer flags ext and brk:
  - Byte E0 sets ext. Byte F0 sets brk. No event is generated for either.
  - Any other byte generates event {code, ext, brk}, then clears both flags.
  - FrameError also clears both flags.
- Key map:
  - ext and LEFT_CODE -> left key.
  - ext and RIGHT_CODE -> right key.
  - not ext and JUMP_CODE -> jump key.
  - All other events change only ScanCode.
  - Make sets the held bit. Break clears it.
- Direction arbitration:
  - Register lastDir records the most recent left/right make.
  - Only left held -> GoLeft. Only right held -> GoRight.
  - Both held -> the lastDir key only.
  - Neither held -> both 0.
  - GoLeft and GoRight are never 1 together.
- Jump pulses only on a jump make while jump is not already held, so typematic repeats are suppressed.
- Reset values: all outputs 0, FSM IDLE, flags/held bits/lastDir 0, watchdog 0.
- Reset mid-frame discards the partial byte and raises no FrameError.

## Timing
- Synchronizer latency: 2 cycles from pin to synced value; the edge is detected on the 3rd cycle.
- Stop-bit edge cycle k: ScanValid, ScanCode, FrameError, GoLeft/GoRight and Jump are all registered and valid at cycle k+1.
- Prefix bytes E0/F0 still pulse ScanValid with ScanCode = E0/F0.
- Minimum inter-edge spacing supported: 3 Clock cycles.
- Timeout: FrameError at cycle t+TIMEOUT_CYCLES, where t is the last edge cycle.
- Simultaneous timeout and edge in the same cycle: the edge wins and the counter clears.

## Configuration
- PS2_PARITY_CHECK_EN defined: the frame passes only if the 8 data bits plus the parity bit have odd parity. On failure the byte is dropped and FrameError pulses.
- Not defined: the parity bit is sampled and ignored, and only the stop bit is checked.

## Test plan
- Frame 0x1C, odd parity, stop 1 -> ScanValid 1 cycle after the stop edge, ScanCode=1C, GoLeft=GoRight=0.
- Sequence E0 6B -> GoLeft=1. Then E0 74 -> GoRight=1, GoLeft=0. Then E0 F0 74 -> GoLeft=1 again. Then E0 F0 6B -> both 0.
- Sequence 29, 29, 29 then F0 29 -> exactly one Jump pulse, at the first 29.
- Frame 0x1C with wrong parity, PS2_PARITY_CHECK_EN defined -> FrameError pulse, no ScanValid. Same frame without the macro -> ScanValid, ScanCode=1C.
- Start bit plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES (set to 100) -> FrameError at edge+100. The next full frame 0x29 is received correctly.
- Reset asserted mid-frame while GoLeft=1 -> GoLeft=0 and FSM IDLE on the next cycle, no FrameError. A following frame decodes normally.

Source files
------------

// File: rtl/ps2_key_controller.sv
// ps2_key_controller
// PS/2 receiver and scan-code sequencer. Oversamples the keyboard pins on
// clock_i, frames 11-bit packets, aborts stalled frames with a watchdog,
// folds E0/F0 prefixes into make/break events and drives the movement
// outputs go_left_o / go_right_o (levels) and jump_o (pulse).
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose 8 data
// bits plus parity bit do not have odd parity. Without it the parity bit
// is sampled and ignored and only the stop bit is checked.
module ps2_key_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74,
    parameter logic [7:0]  JUMP_CODE      = 8'h29
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] scan_code_o,
    output logic       scan_valid_o,
    output logic       frame_error_o,
    output logic       go_left_o,
    output logic       go_right_o,
    output logic       jump_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [WD_W-1:0] wd_q;
    logic            ext_q, brk_q;
    logic            left_held_q, right_held_q, jump_held_q, last_dir_q;
    logic [7:0]      scan_code_q;
    logic            scan_valid_q, frame_error_q, go_left_q, go_right_q, jump_q;

    logic            edge_w, dat_w, frame_ok_w, byte_ok_w, frame_bad_w, timeout_w;
    logic [WD_W-1:0] wd_inc_w;
    logic            ext_d, brk_d, left_held_d, right_held_d, jump_held_d, last_dir_d;
    logic            go_left_d, go_right_d, jump_d;

    // Two-flop synchronizers on both pins plus the delayed clock for edge detect.
    // Reset to 0 so that an idle-high bus cannot look like a falling edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign edge_w = clk_prev_q & ~clk_sync_q[1];
    assign dat_w  = dat_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok_w = dat_w & (^{shift_q, parity_q});
`else
    assign frame_ok_w = dat_w;
`endif

    // The counter reads n-1 in the n-th cycle after an edge, so the abort is
    // taken when the incremented value reaches TIMEOUT_CYCLES-1; FrameError
    // then shows TIMEOUT_CYCLES cycles after the last edge. An edge in the
    // same cycle always wins.
    assign wd_inc_w    = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
    assign timeout_w   = (state_q != S_IDLE) && !edge_w && (wd_inc_w == WD_LAST);
    assign byte_ok_w   = edge_w && (state_q == S_STOP) && frame_ok_w;
    assign frame_bad_w = (edge_w && (state_q == S_STOP) && !frame_ok_w) || timeout_w;

    // Prefix flags, held-key state and direction arbitration for the next cycle.
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        left_held_d  = left_held_q;
        right_held_d = right_held_q;
        jump_held_d  = jump_held_q;
        last_dir_d   = last_dir_q;
        jump_d       = 1'b0;
        if (frame_bad_w) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_w) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q && shift_q == LEFT_CODE) begin
                    left_held_d = !brk_q;
                    if (!brk_q) last_dir_d = 1'b0;
                end else if (ext_q && shift_q == RIGHT_CODE) begin
                    right_held_d = !brk_q;
                    if (!brk_q) last_dir_d = 1'b1;
                end else if (!ext_q && shift_q == JUMP_CODE) begin
                    jump_d      = !brk_q && !jump_held_q;
                    jump_held_d = !brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        // last_dir 0 = left, 1 = right; it only matters when both are held.
        go_left_d  = left_held_d  & (~right_held_d | ~last_dir_d);
        go_right_d = right_held_d & (~left_held_d  |  last_dir_d);
    end

    // Frame FSM, watchdog and all registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wd_q          <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            left_held_q   <= 1'b0;
            right_held_q  <= 1'b0;
            jump_held_q   <= 1'b0;
            last_dir_q    <= 1'b0;
            scan_code_q   <= '0;
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            go_left_q     <= 1'b0;
            go_right_q    <= 1'b0;
            jump_q        <= 1'b0;
        end else begin
            scan_valid_q  <= 1'b0;
            frame_error_q <= frame_bad_w;
            wd_q          <= (state_q == S_IDLE || edge_w) ? '0 : wd_inc_w;
            if (edge_w) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_w) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_w, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_q <= dat_w;
                        state_q  <= S_STOP;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        if (frame_ok_w) begin
                            scan_code_q  <= shift_q;
                            scan_valid_q <= 1'b1;
                        end
                    end
                endcase
            end else if (timeout_w) begin
                state_q <= S_IDLE;
            end
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            left_held_q  <= left_held_d;
            right_held_q <= right_held_d;
            jump_held_q  <= jump_held_d;
            last_dir_q   <= last_dir_d;
            go_left_q    <= go_left_d;
            go_right_q   <= go_right_d;
            jump_q       <= jump_d;
        end
    end

    assign scan_code_o   = scan_code_q;
    assign scan_valid_o  = scan_valid_q;
    assign frame_error_o = frame_error_q;
    assign go_left_o     = go_left_q;
    assign go_right_o    = go_right_q;
    assign jump_o        = jump_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller with a short watchdog (100 cycles).
module tb_ps2_key_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_error, go_left, go_right, jump;

    int cyc = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    int n_valid = 0, n_ferr = 0, n_jump = 0, n_both = 0;
    int valid_cyc = -1, ferr_cyc = -1, jump_cyc = -1;
    logic [7:0] last_code = 8'h00;
    logic left_at = 1'b0, right_at = 1'b0;

    ps2_key_controller #(
        .TIMEOUT_CYCLES(100),
        .LEFT_CODE(8'h6B),
        .RIGHT_CODE(8'h74),
        .JUMP_CODE(8'h29)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .scan_code_o(scan_code),
        .scan_valid_o(scan_valid),
        .frame_error_o(frame_error),
        .go_left_o(go_left),
        .go_right_o(go_right),
        .jump_o(jump)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (scan_valid) begin
            n_valid++;
            valid_cyc = cyc;
            last_code = scan_code;
            left_at   = go_left;
            right_at  = go_right;
        end
        if (frame_error) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (jump) begin
            n_jump++;
            jump_cyc = cyc;
        end
        if (go_left && go_right) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit; fall_c is the cycle in which the pin clock went low.
    task automatic send_bit(input logic b, output int fall_c);
        ps2_dat = b;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        fall_c = cyc;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, output int stop_c);
        int fc;
        send_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) send_bit(d[i], fc);
        send_bit((~^d) ^ bad_par, fc);
        send_bit(1'b1, stop_c);
        ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int sc;
        send_frame(d, 1'b0, sc);
    endtask

    initial begin
        int sc, fc, v0, f0, j0, first_c;

        // Reset state
        repeat (4) @(negedge clk);
        check_eq("rst_outputs", {scan_code, scan_valid, frame_error, go_left, go_right, jump}, 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("idle_no_pulse", n_valid + n_ferr + n_jump, 0);

        // Plain frame 0x1C
        send_frame(8'h1C, 1'b0, sc);
        check_eq("1c_valid_cnt", n_valid, 1);
        check_eq("1c_valid_cycle", valid_cyc, sc + 3);
        check_eq("1c_code", scan_code, 8'h1C);
        check_eq("1c_dirs", {go_left, go_right}, 2'b00);
        check_eq("1c_no_ferr", n_ferr, 0);

        // Direction arbitration
        v0 = n_valid;
        send_byte(8'hE0);
        check_eq("e0_prefix_code", last_code, 8'hE0);
        send_frame(8'h6B, 1'b0, sc);
        check_eq("left_valid_cycle", valid_cyc, sc + 3);
        check_eq("left_at_valid", {left_at, right_at}, 2'b10);
        check_eq("prefix_pulses", n_valid - v0, 2);
        send_byte(8'hE0); send_byte(8'h74);
        check_eq("both_last_right", {go_left, go_right}, 2'b01);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_eq("right_released", {go_left, go_right}, 2'b10);
        check_eq("brk_code", scan_code, 8'h74);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check_eq("all_released", {go_left, go_right}, 2'b00);

        // Jump typematic suppression
        j0 = n_jump;
        send_frame(8'h29, 1'b0, first_c);
        send_byte(8'h29); send_byte(8'h29);
        send_byte(8'hF0); send_byte(8'h29);
        check_eq("jump_once", n_jump - j0, 1);
        check_eq("jump_cycle", jump_cyc, first_c + 3);
        check_eq("jump_no_dirs", {go_left, go_right}, 2'b00);

        // Wrong parity
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h1C, 1'b1, sc);
`ifdef PS2_PARITY_CHECK_EN
        check_eq("badpar_ferr", n_ferr - f0, 1);
        check_eq("badpar_no_valid", n_valid - v0, 0);
        check_eq("badpar_ferr_cycle", ferr_cyc, sc + 3);
`else
        check_eq("badpar_valid", n_valid - v0, 1);
        check_eq("badpar_code", scan_code, 8'h1C);
        check_eq("badpar_no_ferr", n_ferr - f0, 0);
`endif

        // Bad stop bit always fails
        v0 = n_valid; f0 = n_ferr;
        send_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) send_bit(1'b1, fc);
        send_bit(1'b1, fc);
        send_bit(1'b0, sc);
        ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("badstop_ferr", n_ferr - f0, 1);
        check_eq("badstop_no_valid", n_valid - v0, 0);

        // Glitch edge with data high is ignored
        f0 = n_ferr; v0 = n_valid;
        send_bit(1'b1, fc);
        repeat (120) @(negedge clk);
        check_eq("glitch_ignored", (n_ferr - f0) + (n_valid - v0), 0);

        // Timeout after a break prefix; the abort must clear the prefix
        send_byte(8'hF0);
        f0 = n_ferr; v0 = n_valid;
        send_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) send_bit(1'b1, fc);
        repeat (110) @(negedge clk);
        check_eq("timeout_ferr", n_ferr - f0, 1);
        check_eq("timeout_cycle", ferr_cyc, fc + 102);
        check_eq("timeout_no_valid", n_valid - v0, 0);
        j0 = n_jump;
        send_byte(8'h29);
        check_eq("after_timeout_code", scan_code, 8'h29);
        check_eq("after_timeout_jump", n_jump - j0, 1);
        send_byte(8'hF0); send_byte(8'h29);

        // Reset mid-frame while left is held
        send_byte(8'hE0); send_byte(8'h6B);
        check_eq("pre_reset_left", go_left, 1'b1);
        f0 = n_ferr;
        send_bit(1'b0, fc);
        for (int i = 0; i < 3; i++) send_bit(1'b1, fc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_left_cleared", {go_left, go_right}, 2'b00);
        repeat (150) @(negedge clk);
        check_eq("reset_no_ferr", n_ferr - f0, 0);
        v0 = n_valid;
        send_frame(8'h1C, 1'b0, sc);
        check_eq("post_reset_valid", n_valid - v0, 1);
        check_eq("post_reset_code", scan_code, 8'h1C);
        check_eq("post_reset_cycle", valid_cyc, sc + 3);

        check_eq("never_both_dirs", n_both, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
